// File: rtl/ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ex_hazard_ctrl
// Purpose  : Execute-stage pipeline controller. Each cycle it decides whether
//            the instruction held in decode issues into EX, stalls, or is
//            flushed. It covers load-use hazards, taken-branch flushes, CSR
//            serialisation (drain in-flight work first) and memory
//            back-pressure.
// Ports    : i_clk, i_rst_n         clock (rising edge), async active-low reset
//            i_id_*                 decode-stage instruction attributes
//            i_ex_is_load, i_ex_rd  EX-stage load flag and destination register
//            i_ex_branch_taken      EX resolved a taken branch/jump
//            i_mem_busy             memory stall; freezes the controller
//            i_retire               one instruction retired at writeback
//            o_id_ready             decode instruction accepted this cycle
//            o_ex_en                EX pipeline-register load enable
//            o_ex_valid             EX holds a real instruction (registered)
//            o_flush                kill IF/ID contents
//            o_inflight             issued-but-not-retired count
//            o_stall_cycles         stall-cycle counter (EX_HAZARD_STATS_EN)
// Options  : define EX_HAZARD_STATS_EN to add the o_stall_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
module ex_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,   // 1..7
   parameter int INFLIGHT_W   = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_id_valid,
   input  logic [4:0]            i_id_rs1,
   input  logic [4:0]            i_id_rs2,
   input  logic                  i_id_use_rs1,
   input  logic                  i_id_use_rs2,
   input  logic                  i_id_is_csr,
   input  logic                  i_ex_is_load,
   input  logic [4:0]            i_ex_rd,
   input  logic                  i_ex_branch_taken,
   input  logic                  i_mem_busy,
   input  logic                  i_retire,
   output logic                  o_id_ready,
   output logic                  o_ex_en,
   output logic                  o_ex_valid,
   output logic                  o_flush,
   output logic [INFLIGHT_W-1:0] o_inflight
`ifdef EX_HAZARD_STATS_EN
   ,
   output logic [31:0]           o_stall_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [INFLIGHT_W-1:0] c_inflight_max = {INFLIGHT_W{1'b1}};
   localparam logic [2:0]            c_flush_init   = 3'(FLUSH_CYCLES);

   state_t                  r_state;
   state_t                  w_next_state;
   logic [2:0]              r_flush_cnt;
   logic [2:0]              w_next_flush_cnt;
   logic                    r_ex_valid;
   logic [INFLIGHT_W-1:0]   r_inflight;

   logic                    w_load_use;
   logic                    w_br;
   logic                    w_ready;
   logic                    w_issue;
   logic                    w_retire_eff;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= 3'd0;
         r_ex_valid  <= 1'b0;
      end else if (!i_mem_busy) begin
         r_state     <= w_next_state;
         r_flush_cnt <= w_next_flush_cnt;
         // A stall or flush loads a bubble into EX.
         r_ex_valid  <= w_issue;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and combinational outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state     = r_state;
      w_next_flush_cnt = r_flush_cnt;
      w_load_use       = 1'b0;
      w_br             = 1'b0;
      w_ready          = 1'b0;

      w_load_use = r_ex_valid & i_ex_is_load & (i_ex_rd != 5'd0) &
                   ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                    (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));
      w_br       = r_ex_valid & i_ex_branch_taken & ~i_mem_busy;

      // A CSR waits until nothing older is in flight.
      w_ready = (r_state == ST_RUN) & ~w_br & ~i_mem_busy & ~w_load_use &
                (r_inflight != c_inflight_max) &
                ~(i_id_is_csr & (r_inflight != '0));

      // A taken branch overrides every state, including DRAIN.
      if (w_br) begin
         w_next_state     = ST_FLUSH;
         w_next_flush_cnt = c_flush_init;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (i_id_valid & i_id_is_csr & (r_inflight != '0))
                  w_next_state = ST_DRAIN;
            end
            ST_FLUSH: begin
               w_next_flush_cnt = (r_flush_cnt != 3'd0) ? r_flush_cnt - 3'd1 : 3'd0;
               if (r_flush_cnt <= 3'd1)
                  w_next_state = ST_RUN;
            end
            ST_DRAIN: begin
               if (r_inflight == '0)
                  w_next_state = ST_RUN;
            end
            default: w_next_state = ST_RUN;
         endcase
      end
   end

   assign w_issue      = i_id_valid & w_ready;
   assign w_retire_eff = i_retire & (r_inflight != '0);

   // Combinational outputs are held low while reset is asserted.
   assign o_id_ready = i_rst_n & w_ready;
   assign o_ex_en    = i_rst_n & ~i_mem_busy;
   assign o_flush    = i_rst_n & (w_br | (r_state == ST_FLUSH));
   assign o_ex_valid = r_ex_valid;
   assign o_inflight = r_inflight;

   // ------------------------------------------------------------------------
   // In-flight counter. Retire is honoured even under memory back-pressure;
   // issue is impossible then, so only the decrement path can fire.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_inflight <= '0;
      end else if (w_issue & ~w_retire_eff) begin
         r_inflight <= r_inflight + INFLIGHT_W'(1);
      end else if (~w_issue & w_retire_eff) begin
         r_inflight <= r_inflight - INFLIGHT_W'(1);
      end
   end

`ifdef EX_HAZARD_STATS_EN
   logic [31:0] r_stall_cycles;

   // Counts decode-side stalls only; flush cycles are not stalls.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cycles <= 32'd0;
      end else if (i_id_valid & ~w_ready & ~o_flush & (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign o_stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_hazard_ctrl
// Purpose  : Self-checking bench for ex_hazard_ctrl (FLUSH_CYCLES=2,
//            INFLIGHT_W=2). Directed scenarios followed by random traffic,
//            all compared against a behavioural model of the controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_hazard_ctrl;

   localparam int FC      = 2;
   localparam int IW      = 2;
   localparam int MAX_INF = (1 << IW) - 1;

   localparam int MODE_RUN   = 0;
   localparam int MODE_FLUSH = 1;
   localparam int MODE_DRAIN = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          id_valid, id_use_rs1, id_use_rs2, id_is_csr;
   logic [4:0]    id_rs1, id_rs2, ex_rd;
   logic          ex_is_load, ex_branch_taken, mem_busy, retire;
   logic          id_ready, ex_en, ex_valid, flush;
   logic [IW-1:0] inflight;
`ifdef EX_HAZARD_STATS_EN
   logic [31:0]   stall_cycles;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   int  m_mode;
   int  m_flush_left;
   bit  m_ex_valid;
   int  m_inflight;
   longint m_stall;

   always #5 clk = ~clk;

   ex_hazard_ctrl #(
      .FLUSH_CYCLES (FC),
      .INFLIGHT_W   (IW)
   ) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_id_valid        (id_valid),
      .i_id_rs1          (id_rs1),
      .i_id_rs2          (id_rs2),
      .i_id_use_rs1      (id_use_rs1),
      .i_id_use_rs2      (id_use_rs2),
      .i_id_is_csr       (id_is_csr),
      .i_ex_is_load      (ex_is_load),
      .i_ex_rd           (ex_rd),
      .i_ex_branch_taken (ex_branch_taken),
      .i_mem_busy        (mem_busy),
      .i_retire          (retire),
      .o_id_ready        (id_ready),
      .o_ex_en           (ex_en),
      .o_ex_valid        (ex_valid),
      .o_flush           (flush),
      .o_inflight        (inflight)
`ifdef EX_HAZARD_STATS_EN
      ,
      .o_stall_cycles    (stall_cycles)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode       = MODE_RUN;
      m_flush_left = 0;
      m_ex_valid   = 1'b0;
      m_inflight   = 0;
      m_stall      = 0;
   endtask

   task automatic drive_idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_is_csr = 0; ex_is_load = 0; ex_rd = 0; ex_branch_taken = 0;
      mem_busy = 0; retire = 0;
   endtask

   task automatic check_reset_outputs(input string ph);
      check({ph, ":id_ready"}, 32'(id_ready), 32'd0);
      check({ph, ":ex_en"},    32'(ex_en),    32'd0);
      check({ph, ":flush"},    32'(flush),    32'd0);
      check({ph, ":ex_valid"}, 32'(ex_valid), 32'd0);
      check({ph, ":inflight"}, 32'(inflight), 32'd0);
`ifdef EX_HAZARD_STATS_EN
      check({ph, ":stall_cycles"}, stall_cycles, 32'd0);
`endif
   endtask

   // One clock cycle: apply inputs, compare outputs mid-cycle against the
   // model, then advance the model across the rising edge.
   task automatic step(input string ph, input bit idv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input bit csr, input bit ld, input logic [4:0] rd,
                       input bit tk, input bit busy, input bit ret);
      bit lu, br, rdy, fl, iss, ret_eff;
      int old_inf;
      id_valid = idv; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      id_is_csr = csr; ex_is_load = ld; ex_rd = rd; ex_branch_taken = tk;
      mem_busy = busy; retire = ret;
      @(negedge clk);
      lu  = m_ex_valid && ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      br  = m_ex_valid && tk && !busy;
      fl  = br || (m_mode == MODE_FLUSH);
      rdy = (m_mode == MODE_RUN) && !br && !busy && !lu && (m_inflight < MAX_INF) &&
            !(csr && m_inflight > 0);
      iss = idv && rdy;
      check({ph, ":id_ready"}, 32'(id_ready), 32'(rdy));
      check({ph, ":ex_en"},    32'(ex_en),    32'(!busy));
      check({ph, ":flush"},    32'(flush),    32'(fl));
      check({ph, ":ex_valid"}, 32'(ex_valid), 32'(m_ex_valid));
      check({ph, ":inflight"}, 32'(inflight), 32'(m_inflight));
`ifdef EX_HAZARD_STATS_EN
      check({ph, ":stall_cycles"}, stall_cycles, 32'(m_stall));
`endif
      @(posedge clk);
      #1;
      old_inf = m_inflight;
      ret_eff = ret && old_inf > 0;
      m_inflight = old_inf + (iss ? 1 : 0) - (ret_eff ? 1 : 0);
      if (idv && !rdy && !fl && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (!busy) begin
         m_ex_valid = iss;
         if (br) begin
            m_mode = MODE_FLUSH;
            m_flush_left = FC;
         end else if (m_mode == MODE_RUN) begin
            if (idv && csr && old_inf > 0) m_mode = MODE_DRAIN;
         end else if (m_mode == MODE_FLUSH) begin
            m_flush_left--;
            if (m_flush_left == 0) m_mode = MODE_RUN;
         end else if (m_mode == MODE_DRAIN) begin
            if (old_inf == 0) m_mode = MODE_RUN;
         end
      end
   endtask

   initial begin
      drive_idle();
      model_reset();
      rst_n = 1'b0;
      #2;
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Load-use on x5, then the same shape with rd=x0
      step("lu_issue",  1, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 0, 0, 0);
      step("lu_stall",  1, 5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 0, 0, 1);
      step("lu_bubble", 1, 5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 0, 0, 0);
      step("lu_x0",     1, 5'd0, 5'd0, 1, 1, 0, 1, 5'd0, 0, 0, 1);

      // Taken branch: one br cycle plus FC flush cycles
      step("br_take",   1, 5'd3, 5'd4, 1, 1, 0, 0, 5'd0, 1, 0, 1);
      step("br_fl1",    1, 5'd3, 5'd4, 1, 1, 0, 0, 5'd0, 1, 0, 1);
      step("br_fl2",    1, 5'd3, 5'd4, 1, 1, 0, 0, 5'd0, 0, 0, 0);
      step("br_after",  0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1);

      // Memory back-pressure in the middle of a flush
      step("mb_issue",  1, 5'd1, 5'd1, 0, 0, 0, 0, 5'd0, 0, 0, 0);
      step("mb_br",     1, 5'd1, 5'd1, 0, 0, 0, 0, 5'd0, 1, 0, 1);
      step("mb_fl1",    1, 5'd1, 5'd1, 0, 0, 0, 0, 5'd0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         step("mb_busy", 1, 5'd1, 5'd1, 0, 0, 0, 0, 5'd0, 1, 1, 0);
      step("mb_fl2",    1, 5'd1, 5'd1, 0, 0, 0, 0, 5'd0, 0, 0, 0);
      step("mb_run",    0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1);
      step("mb_idle",   0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1);

      // Fill to the limit, then CSR drain
      for (int i = 0; i < 3; i++)
         step("lim_issue", 1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 0);
      step("lim_full",  1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 0);
      step("csr_enter", 1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step("csr_ret", 1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 1);
      step("csr_zero",  1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0);
      step("csr_issue", 1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0);
      step("iss_ret",   1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 1);
      step("iss_ret2",  1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 0);

      // Reach DRAIN with two in flight, then reset asynchronously
      step("rd_csr",    1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0);
      step("rd_drain",  1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0);
      check("rd_pre:inflight", 32'(inflight), 32'd2);
      drive_idle();
      id_valid = 1; id_is_csr = 1;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("rst_mid");
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Random traffic with small register numbers so hazards are frequent
      for (int i = 0; i < 800; i++) begin
         step("rand",
              $urandom_range(0, 9) < 8,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) == 0,
              5'($urandom_range(0, 3)),
              $urandom_range(0, 11) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) < 4);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
